// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the PicoBlaze program loader.
package prog_loader_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 18;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WEA_W   = 4;

    localparam logic [BYTE_W-1:0] DEFAULT_HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_HI = 3'd1,
        CNT_LO = 3'd2,
        B0     = 3'd3,
        B1     = 3'd4,
        B2     = 3'd5,
        CHK    = 3'd6
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// UART byte input and program-memory write port of the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic [BYTE_W-1:0]  rx_data;
    logic               rx_valid;
    logic [ADDR_W-1:0]  address;
    logic [INSTR_W-1:0] instruction;
    logic [WEA_W-1:0]   WEA;
    logic               cpu_reset;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  rx_data, rx_valid,
        output address, instruction, WEA, cpu_reset, busy, done, err
    );

    modport slave (
        output rx_data, rx_valid,
        input  address, instruction, WEA, cpu_reset, busy, done, err
    );

endinterface

// File: rtl/prog_loader_rx_timeout.sv
// Watchdog: expires after TIMEOUT_CYCLES enabled cycles with no clear.
module rx_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = enable && !clear && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/prog_loader.sv
// Loads a framed program image from UART bytes into PicoBlaze program memory.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 1000000,
    parameter logic [BYTE_W-1:0] HDR_BYTE       = DEFAULT_HDR_BYTE
) (
    input  logic          clk,
    input  logic          reset,
    prog_loader_if.master bus
);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   count, count_n;
    logic [ADDR_W-1:0]   word_hi, word_hi_n;
    logic [BYTE_W-1:0]   checksum, checksum_n;
    logic [ADDR_W-1:0]   address, address_n;
    logic [INSTR_W-1:0]  instruction, instruction_n;
    logic [WEA_W-1:0]    wea, wea_n;
    logic                cpu_reset, cpu_reset_n;
    logic                busy, busy_n;
    logic                done, done_n;
    logic                err, err_n;
    logic                expired;
    logic [BYTE_W-1:0]   rx;
    logic                rx_valid;

    assign rx       = bus.rx_data;
    assign rx_valid = bus.rx_valid;

    rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid),
        .enable (state != IDLE),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            word_hi     <= '0;
            checksum    <= '0;
            address     <= '0;
            instruction <= '0;
            wea         <= '0;
            cpu_reset   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            word_hi     <= word_hi_n;
            checksum    <= checksum_n;
            address     <= address_n;
            instruction <= instruction_n;
            wea         <= wea_n;
            cpu_reset   <= cpu_reset_n;
            busy        <= busy_n;
            done        <= done_n;
            err         <= err_n;
        end
    end

    always_comb begin
        state_n       = state;
        count_n       = count;
        word_hi_n     = word_hi;
        checksum_n    = checksum;
        address_n     = address;
        instruction_n = instruction;
        wea_n         = '0;
        cpu_reset_n   = cpu_reset;
        done_n        = 1'b0;
        err_n         = err;

        // Address advances once the write cycle has been presented to memory.
        if (wea != '0) begin
            address_n = address + ADDR_W'(1);
        end

        unique case (state)
            IDLE: begin
                if (rx_valid && (rx == HDR_BYTE)) begin
                    state_n     = CNT_HI;
                    err_n       = 1'b0;
                    cpu_reset_n = 1'b1;
                    checksum_n  = '0;
                    address_n   = '0;
                end
            end
            CNT_HI: begin
                if (rx_valid) begin
                    checksum_n = checksum ^ rx;
                    if (rx[7:2] != 6'd0) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        count_n[9:8] = rx[1:0];
                        state_n      = CNT_LO;
                    end
                end
            end
            CNT_LO: begin
                if (rx_valid) begin
                    checksum_n   = checksum ^ rx;
                    count_n[7:0] = rx;
                    state_n      = B0;
                end
            end
            B0: begin
                if (rx_valid) begin
                    checksum_n = checksum ^ rx;
                    if (rx[7:2] != 6'd0) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        word_hi_n[9:8] = rx[1:0];
                        state_n        = B1;
                    end
                end
            end
            B1: begin
                if (rx_valid) begin
                    checksum_n     = checksum ^ rx;
                    word_hi_n[7:0] = rx;
                    state_n        = B2;
                end
            end
            B2: begin
                // address equals the current word index here; the last word has index count.
                if (rx_valid) begin
                    checksum_n    = checksum ^ rx;
                    instruction_n = {word_hi, rx};
                    wea_n         = '1;
                    state_n       = (address == count) ? CHK : B0;
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (rx == checksum) begin
                        done_n      = 1'b1;
                        cpu_reset_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (expired) begin
            state_n = IDLE;
            err_n   = 1'b1;
        end

        busy_n = (state_n != IDLE);
    end

    assign bus.address     = address;
    assign bus.instruction = instruction;
    assign bus.WEA         = wea;
    assign bus.cpu_reset   = cpu_reset;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.err         = err;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued by stimulus, checked by a monitor.
module tb_prog_loader;

    typedef struct packed {
        logic [9:0]  a;
        logic [17:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    int exp_done  = 0;
    logic done_prev = 1'b0;
    wr_t expq[$];

    always #5 clk = ~clk;

    prog_loader_if ifc ();

    prog_loader #(
        .TIMEOUT_CYCLES(16),
        .HDR_BYTE      (8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] b);
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] wgen(input int seed, input int i);
        logic [31:0] v;
        v = 32'(seed) * 32'h0001_3579 + 32'(i) * 32'h0000_9E37 + 32'(i >> 3);
        return v[17:0];
    endfunction

    task automatic load(input int nw, input int seed, input bit bad);
        logic [9:0]  c;
        logic [7:0]  cs;
        logic [17:0] w;
        c  = 10'(nw - 1);
        cs = 8'h00;
        send(8'hA5);
        send({6'b0, c[9:8]});
        cs ^= {6'b0, c[9:8]};
        send(c[7:0]);
        cs ^= c[7:0];
        for (int i = 0; i < nw; i++) begin
            w = wgen(seed, i);
            expq.push_back({10'(i), w});
            send({6'b0, w[17:16]});
            send(w[15:8]);
            send(w[7:0]);
            cs ^= {6'b0, w[17:16]} ^ w[15:8] ^ w[7:0];
        end
        send(bad ? ~cs : cs);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_address"}, 32'(ifc.address), 32'd0);
        chk({tag, "_instruction"}, 32'(ifc.instruction), 32'd0);
        chk({tag, "_wea"}, 32'(ifc.WEA), 32'd0);
        chk({tag, "_cpu_reset"}, 32'(ifc.cpu_reset), 32'd0);
        chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
        chk({tag, "_done"}, 32'(ifc.done), 32'd0);
        chk({tag, "_err"}, 32'(ifc.err), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [17:0] w;
        reset        = 1'b1;
        ifc.rx_data  = 8'h00;
        ifc.rx_valid = 1'b0;

        // Write/done monitor.
        fork
            forever begin
                wr_t e;
                @(negedge clk);
                if (ifc.done === 1'b1) begin
                    done_seen++;
                    chk("done_single_cycle", 32'(done_prev), 32'd0);
                end
                done_prev = ifc.done;
                if (ifc.WEA !== 4'b0000) begin
                    chk("wea_value", 32'(ifc.WEA), 32'hF);
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %h instr %h required no write at %0t",
                                 ifc.address, ifc.instruction, $time);
                    end else begin
                        e = expq.pop_front();
                        chk("write_address", 32'(ifc.address), 32'(e.a));
                        chk("write_instruction", 32'(ifc.instruction), 32'(e.d));
                    end
                end
            end
        join_none

        idle(3);
        reset = 1'b0;
        chk_reset_vals("por");

        // Single-word load with hand-computed checksum 60.
        expq.push_back({10'd0, 18'h23456});
        send(8'hA5);
        chk("hdr_cpu_reset", 32'(ifc.cpu_reset), 32'd1);
        chk("hdr_busy", 32'(ifc.busy), 32'd1);
        send(8'h00);
        send(8'h00);
        send(8'h02);
        send(8'h34);
        send(8'h56);
        send(8'h60);
        chk("t1_done_pulse", 32'(ifc.done), 32'd1);
        exp_done++;
        idle(2);
        chk("t1_done_count", 32'(done_seen), 32'(exp_done));
        chk("t1_cpu_reset", 32'(ifc.cpu_reset), 32'd0);
        chk("t1_err", 32'(ifc.err), 32'd0);
        chk("t1_busy", 32'(ifc.busy), 32'd0);
        chk("t1_address", 32'(ifc.address), 32'd1);
        chk("t1_pending", 32'(expq.size()), 32'd0);

        // Three words, bad checksum, then a good recovery load.
        load(3, 1, 1'b1);
        idle(2);
        chk("t2_err", 32'(ifc.err), 32'd1);
        chk("t2_cpu_reset", 32'(ifc.cpu_reset), 32'd1);
        chk("t2_done_count", 32'(done_seen), 32'(exp_done));
        chk("t2_pending", 32'(expq.size()), 32'd0);
        load(2, 2, 1'b0);
        exp_done++;
        idle(2);
        chk("t2b_err", 32'(ifc.err), 32'd0);
        chk("t2b_cpu_reset", 32'(ifc.cpu_reset), 32'd0);
        chk("t2b_done_count", 32'(done_seen), 32'(exp_done));
        chk("t2b_pending", 32'(expq.size()), 32'd0);

        // Bad count-high byte, then stray byte ignored and header restarts.
        send(8'hA5);
        send(8'h04);
        chk("t3_err", 32'(ifc.err), 32'd1);
        chk("t3_busy", 32'(ifc.busy), 32'd0);
        chk("t3_cpu_reset", 32'(ifc.cpu_reset), 32'd1);
        send(8'h11);
        chk("t3_stray_busy", 32'(ifc.busy), 32'd0);
        chk("t3_stray_err", 32'(ifc.err), 32'd1);
        send(8'hA5);
        chk("t3_restart_busy", 32'(ifc.busy), 32'd1);
        chk("t3_restart_err", 32'(ifc.err), 32'd0);

        // Continue that load and stall after B1 to trigger the 16-cycle timeout.
        send(8'h00);
        send(8'h00);
        send(8'h01);
        send(8'h23);
        idle(15);
        chk("t4_busy_before", 32'(ifc.busy), 32'd1);
        chk("t4_err_before", 32'(ifc.err), 32'd0);
        idle(1);
        chk("t4_busy_after", 32'(ifc.busy), 32'd0);
        chk("t4_err_after", 32'(ifc.err), 32'd1);
        chk("t4_cpu_reset", 32'(ifc.cpu_reset), 32'd1);
        chk("t4_pending", 32'(expq.size()), 32'd0);

        // Reset asserted together with the B1 byte of word 5.
        send(8'hA5);
        send(8'h00);
        send(8'h09);
        for (int i = 0; i < 4; i++) begin
            w = wgen(4, i);
            expq.push_back({10'(i), w});
            send({6'b0, w[17:16]});
            send(w[15:8]);
            send(w[7:0]);
        end
        w = wgen(4, 4);
        send({6'b0, w[17:16]});
        ifc.rx_data  = w[15:8];
        ifc.rx_valid = 1'b1;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        ifc.rx_valid = 1'b0;
        chk_reset_vals("midreset");
        idle(5);
        chk("t5_busy", 32'(ifc.busy), 32'd0);
        chk("t5_pending", 32'(expq.size()), 32'd0);

        // Full 1024-word image, bytes back to back.
        load(1024, 3, 1'b0);
        exp_done++;
        idle(2);
        chk("t6_done_count", 32'(done_seen), 32'(exp_done));
        chk("t6_err", 32'(ifc.err), 32'd0);
        chk("t6_cpu_reset", 32'(ifc.cpu_reset), 32'd0);
        chk("t6_address_wrap", 32'(ifc.address), 32'd0);
        chk("t6_pending", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000: idle cycles between received bytes before an in-progress load aborts.
REQ-002 Parameter HDR_BYTE, default 8'hA5: header byte that starts a load.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-007 address  output  10  program-memory write address.
REQ-008 instruction  output  18  program-memory write data, bits [17:16] to parity, [15:0] to data.
REQ-009 WEA  output  4  program-memory byte write enables.
REQ-010 cpu_reset  output  1  holds the PicoBlaze in reset while a load is in progress or has failed.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when a load completes with a good checksum.
REQ-013 err  output  1  sticky error flag.

Function
REQ-014 States SHALL be IDLE, CNT_HI, CNT_LO, B0, B1, B2 and CHK; a byte is consumed only on a cycle where rx_valid=1.
REQ-015 In IDLE, a byte equal to HDR_BYTE SHALL go to CNT_HI, clear err, set cpu_reset=1, clear the checksum and set address=0; any other byte SHALL be ignored.
REQ-016 In CNT_HI, bits [1:0] SHALL load count[9:8]; nonzero bits [7:2] SHALL set err and return to IDLE.
REQ-017 In CNT_LO, the byte SHALL load count[7:0] and go to B0; the load size is count+1 words (1..1024).
REQ-018 In B0, bits [1:0] SHALL load word[17:16]; nonzero bits [7:2] SHALL set err and return to IDLE.
REQ-019 B1 SHALL load word[15:8]; B2 SHALL load word[7:0].
REQ-020 The cycle after the B2 byte is accepted, WEA SHALL be 4'b1111 for exactly one cycle, with address and instruction stable for that cycle; latency is 1 clk.
REQ-021 After each write, address SHALL increment by 1 (10-bit, no saturation); the B2 transition goes to CHK when the accepted word is word number count+1, otherwise to B0.
REQ-022 A byte accepted during the WEA cycle SHALL be processed normally; no byte is dropped.
REQ-023 The checksum SHALL be the 8-bit XOR of every byte from CNT_HI through the last B2 byte.
REQ-024 In CHK, a byte equal to the checksum SHALL pulse done, clear cpu_reset and go to IDLE; a mismatch SHALL set err, keep cpu_reset=1 and go to IDLE.
REQ-025 In any non-IDLE state, TIMEOUT_CYCLES consecutive cycles without rx_valid SHALL set err, keep cpu_reset=1 and go to IDLE; the count restarts on every rx_valid.
REQ-026 err and cpu_reset=1 SHALL persist after an error until the next HDR_BYTE is accepted in IDLE.
REQ-027 HDR_BYTE received in any non-IDLE state SHALL be treated as ordinary data.
REQ-028 An address wrap from 1023 to 0 is possible only after 1024 words and SHALL not be flagged.

Reset
REQ-029 On reset: state=IDLE, address=0, instruction=0, WEA=0, cpu_reset=0 so the power-up program runs, busy=0, done=0, err=0, checksum=0, timeout counter=0.
REQ-030 reset SHALL take priority over rx_valid in the same cycle; a reset in the middle of a load abandons the load with no further writes.

Structure
REQ-031 Shared package prog_loader_pkg SHALL hold the state enum, the default HDR_BYTE, ADDR_W=10 and INSTR_W=18.
REQ-032 One sub-module, rx_timeout, SHALL implement the TIMEOUT_CYCLES watchdog with inputs clk, reset, clear and enable, and output expired.

Verification
REQ-033 Send A5,00,00,02,34,56,(00^00^02^34^56=60) -> one WEA=1111 cycle with address=0 and instruction=18'h23456; done pulses; cpu_reset goes 1 then 0; err=0.
REQ-034 Load 3 words with a bad checksum -> writes occur at addresses 0, 1 and 2; err=1 and cpu_reset stays 1; a following good load clears both.
REQ-035 Send A5,04 -> err=1 and state returns to IDLE; send 11,A5 while in IDLE -> 11 is ignored and A5 starts a load.
REQ-036 With TIMEOUT_CYCLES=16, stop sending after the B1 byte -> err=1 and IDLE 16 cycles after the last byte; WEA never asserts.
REQ-037 Assert reset during B1 of word 5 -> all outputs return to their reset values next cycle with no further WEA.
REQ-038 Send count 3FF with 1024 words back-to-back (rx_valid every cycle) -> 1024 writes, the last at address 1023, with no byte lost.
